// File: rtl/memory_bus_master_if.sv
// CPU request/response handshake plus the RAM-side select, strobe and address lines.
// The shared data bus is a module-level inout so it resolves as a real tri-state net.
interface memory_bus_master_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [15:0] reqAddr;
    logic [7:0]  reqWdata;
    logic        rspValid;
    logic [7:0]  rspData;
    logic        chipSelect;
    logic        writeEnable;
    logic [13:0] address;

    modport master (
        input  reqValid, reqWrite, reqAddr, reqWdata,
        output reqReady, rspValid, rspData, chipSelect, writeEnable, address
    );

    modport slave (
        output reqValid, reqWrite, reqAddr, reqWdata,
        input  reqReady, rspValid, rspData, chipSelect, writeEnable, address
    );
endinterface

// File: rtl/memory_bus_master.sv
// Single-outstanding CPU initiator for the 16 kB work-RAM: turns load/store requests into
// registered chipSelect/writeEnable/address/data cycles and returns a one-cycle response.
module memory_bus_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [1:0]  RAM_BASE     = 2'b00,
    parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
    input  logic                       clk,
    input  logic                       nReset,
    memory_bus_master_if.master        bus,
    inout  wire  [7:0]                 data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESPOND} state_e;

    // READ lasts READ_LATENCY+1 cycles: the count runs 0..READ_LATENCY.
    localparam logic [1:0] LAST_READ = 2'(READ_LATENCY);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic        oe_q, oe_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        oe_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    addr_d  = bus.reqAddr[13:0];
                    wdata_d = bus.reqWdata;
                    if (bus.reqAddr[15:14] != RAM_BASE) begin
                        state_d    = RESPOND;
                        rsp_data_d = bus.reqWrite ? 8'h00 : OPEN_BUS;
                    end else if (bus.reqWrite) begin
                        state_d = WRITE;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = READ;
                        cs_d    = 1'b1;
                        cnt_d   = 2'd0;
                    end
                end
            end
            WRITE: begin
                // Select, strobe and data enable all drop on this same edge.
                state_d    = RESPOND;
                rsp_data_d = 8'h00;
            end
            READ: begin
                if (cnt_q == LAST_READ) begin
                    state_d    = RESPOND;
                    rsp_data_d = data;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    cs_d  = 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the reset is asynchronous so a
    // transfer is abandoned and the bus released the moment nReset falls.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 14'h0000;
            wdata_q    <= 8'h00;
            rsp_data_q <= 8'h00;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.reqReady    = (state_q == IDLE);
    assign bus.rspValid    = (state_q == RESPOND);
    assign bus.rspData     = rsp_data_q;
    assign bus.chipSelect  = cs_q;
    assign bus.writeEnable = we_q;
    assign bus.address     = addr_q;
    assign data            = oe_q ? wdata_q : 8'hzz;
endmodule

// File: tb/tb_memory_bus_master.sv
// Directed and random checks of memory_bus_master at READ_LATENCY 1 and 2 against
// behavioural synchronous RAM models hanging off each shared data bus.
module tb_memory_bus_master;
    logic clk    = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    memory_bus_master_if bus1 ();
    memory_bus_master_if bus2 ();
    wire [7:0] data1;
    wire [7:0] data2;

    memory_bus_master #(.READ_LATENCY(1)) dut1 (.clk(clk), .nReset(nReset), .bus(bus1), .data(data1));
    memory_bus_master #(.READ_LATENCY(2)) dut2 (.clk(clk), .nReset(nReset), .bus(bus2), .data(data2));

    // RAM models: write on the edge, read data appears READ_LATENCY edges after the address.
    logic [7:0]  mem1 [16384] = '{default: 8'h00};
    logic [7:0]  mem2 [16384] = '{default: 8'h00};
    logic [2:0]  rv1 = 3'b000;
    logic [2:0]  rv2 = 3'b000;
    logic [13:0] ra1 [3];
    logic [13:0] ra2 [3];

    always @(posedge clk) begin
        if (bus1.chipSelect && bus1.writeEnable) mem1[bus1.address] <= data1;
        rv1    <= {rv1[1:0], bus1.chipSelect & ~bus1.writeEnable};
        ra1[2] <= ra1[1];
        ra1[1] <= ra1[0];
        ra1[0] <= bus1.address;
        if (bus2.chipSelect && bus2.writeEnable) mem2[bus2.address] <= data2;
        rv2    <= {rv2[1:0], bus2.chipSelect & ~bus2.writeEnable};
        ra2[2] <= ra2[1];
        ra2[1] <= ra2[0];
        ra2[0] <= bus2.address;
    end

    assign data1 = rv1[0] ? mem1[ra1[0]] : 8'hzz;
    assign data2 = rv2[1] ? mem2[ra2[1]] : 8'hzz;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int pulses1  = 0;
    int accepts1 = 0;
    logic [7:0]  cur_wd1 = 8'h00, cur_wd2 = 8'h00;
    logic [15:0] cur_a1  = 16'h0, cur_a2  = 16'h0;

    // Bus-safety monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus1.writeEnable && !bus1.chipSelect) viol++;
        if (bus2.writeEnable && !bus2.chipSelect) viol++;
        if (bus1.chipSelect && bus1.writeEnable && data1 !== cur_wd1) viol++;
        if (bus2.chipSelect && bus2.writeEnable && data2 !== cur_wd2) viol++;
        if (bus1.chipSelect && bus1.address !== cur_a1[13:0]) viol++;
        if (bus2.chipSelect && bus2.address !== cur_a2[13:0]) viol++;
        if (bus1.rspValid) pulses1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? bus1.reqReady : bus2.reqReady;
    endfunction
    function automatic logic rsp(input int w);
        return (w == 1) ? bus1.rspValid : bus2.rspValid;
    endfunction
    function automatic logic csel(input int w);
        return (w == 1) ? bus1.chipSelect : bus2.chipSelect;
    endfunction
    function automatic logic [7:0] rdat(input int w);
        return (w == 1) ? bus1.rspData : bus2.rspData;
    endfunction

    // Called at a negedge; returns at the negedge after the response pulse.
    task automatic do_req(input int w, input logic wr, input logic [15:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat, output int cs_cyc);
        int budget;
        if (w == 1) begin
            bus1.reqValid = 1'b1; bus1.reqWrite = wr; bus1.reqAddr = a; bus1.reqWdata = wd;
        end else begin
            bus2.reqValid = 1'b1; bus2.reqWrite = wr; bus2.reqAddr = a; bus2.reqWdata = wd;
        end
        budget = 0;
        while (!rdy(w) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) check("accept_timeout", 32'(budget), 32'd0);
        @(posedge clk);
        if (w == 1) begin
            accepts1++; cur_wd1 = wd; cur_a1 = a;
        end else begin
            cur_wd2 = wd; cur_a2 = a;
        end
        @(negedge clk);
        if (w == 1) bus1.reqValid = 1'b0; else bus2.reqValid = 1'b0;
        lat    = 1;
        cs_cyc = 0;
        while (!rsp(w) && lat < 20) begin
            if (csel(w)) cs_cyc++;
            @(negedge clk);
            lat++;
        end
        rd = rdat(w);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp(w)), 32'd0);
    endtask

    logic [15:0] bb_a   [4] = '{16'h3FFF, 16'h0000, 16'h3FFF, 16'h0000};
    logic        bb_wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  bb_wd  [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
    logic [7:0]  bb_exp [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
    logic [7:0]  ref_mem [16] = '{default: 8'h00};

    initial begin
        logic [7:0] rd;
        int lat, csc, budget, p0;

        bus1.reqValid = 1'b0; bus1.reqWrite = 1'b0; bus1.reqAddr = 16'h0; bus1.reqWdata = 8'h00;
        bus2.reqValid = 1'b0; bus2.reqWrite = 1'b0; bus2.reqAddr = 16'h0; bus2.reqWdata = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_ready",    32'(bus1.reqReady),    32'd1);
        check("rst_rspvalid", 32'(bus1.rspValid),    32'd0);
        check("rst_rspdata",  32'(bus1.rspData),     32'h00);
        check("rst_cs",       32'(bus1.chipSelect),  32'd0);
        check("rst_we",       32'(bus1.writeEnable), 32'd0);
        check("rst_addr",     32'(bus1.address),     32'h0000);
        nReset = 1'b1;
        @(negedge clk);

        // Store then load, latency 1.
        do_req(1, 1'b1, 16'h0123, 8'hA5, rd, lat, csc);
        check("st_lat",  32'(lat), 32'd2);
        check("st_cs",   32'(csc), 32'd1);
        check("st_rd",   32'(rd),  32'h00);
        check("st_mem",  32'(mem1[14'h0123]), 32'hA5);
        do_req(1, 1'b0, 16'h0123, 8'h00, rd, lat, csc);
        check("ld_lat",  32'(lat), 32'd3);
        check("ld_cs",   32'(csc), 32'd2);
        check("ld_rd",   32'(rd),  32'hA5);

        // Store then load, latency 2.
        do_req(2, 1'b1, 16'h0050, 8'h3C, rd, lat, csc);
        check("l2_st_lat", 32'(lat), 32'd2);
        check("l2_st_mem", 32'(mem2[14'h0050]), 32'h3C);
        do_req(2, 1'b0, 16'h0050, 8'h00, rd, lat, csc);
        check("l2_ld_lat", 32'(lat), 32'd4);
        check("l2_ld_cs",  32'(csc), 32'd3);
        check("l2_ld_rd",  32'(rd),  32'h3C);

        // Out-of-window accesses.
        do_req(1, 1'b0, 16'h8000, 8'h00, rd, lat, csc);
        check("oow_ld_lat", 32'(lat), 32'd1);
        check("oow_ld_cs",  32'(csc), 32'd0);
        check("oow_ld_rd",  32'(rd),  32'hFF);
        check("rspdata_hold", 32'(bus1.rspData), 32'hFF);
        do_req(1, 1'b1, 16'hC010, 8'h5A, rd, lat, csc);
        check("oow_st_lat", 32'(lat), 32'd1);
        check("oow_st_cs",  32'(csc), 32'd0);
        check("oow_st_rd",  32'(rd),  32'h00);
        check("oow_st_mem", 32'(mem1[14'h0010]), 32'h00);

        // Back-to-back with reqValid held high.
        bus1.reqValid = 1'b1; bus1.reqWrite = bb_wr[0]; bus1.reqAddr = bb_a[0]; bus1.reqWdata = bb_wd[0];
        for (int i = 0; i < 4; i++) begin
            budget = 0;
            while (!bus1.reqReady && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            @(posedge clk);
            accepts1++;
            cur_wd1 = bus1.reqWdata;
            cur_a1  = bus1.reqAddr;
            @(negedge clk);
            check("b2b_ready_low", 32'(bus1.reqReady), 32'd0);
            if (i < 3) begin
                bus1.reqWrite = bb_wr[i+1]; bus1.reqAddr = bb_a[i+1]; bus1.reqWdata = bb_wd[i+1];
            end else begin
                bus1.reqValid = 1'b0;
            end
            lat = 1;
            while (!bus1.rspValid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("b2b_lat",   32'(lat), bb_wr[i] ? 32'd2 : 32'd3);
            check("b2b_rdata", 32'(bus1.rspData), 32'(bb_exp[i]));
        end
        @(negedge clk);

        // Reset in the middle of a read.
        p0 = pulses1;
        bus1.reqValid = 1'b1; bus1.reqWrite = 1'b0; bus1.reqAddr = 16'h0123;
        @(posedge clk);
        cur_a1 = 16'h0123;
        @(negedge clk);
        bus1.reqValid = 1'b0;
        check("abort_cs_active", 32'(bus1.chipSelect), 32'd1);
        #2 nReset = 1'b0;
        #1;
        check("abort_cs",  32'(bus1.chipSelect),  32'd0);
        check("abort_we",  32'(bus1.writeEnable), 32'd0);
        check("abort_rsp", 32'(bus1.rspValid),    32'd0);
        @(negedge clk);
        nReset = 1'b1;
        check("abort_ready", 32'(bus1.reqReady), 32'd1);
        repeat (5) @(negedge clk);
        check("abort_no_rsp", 32'(pulses1 - p0), 32'd0);

        // Random mixed stress against a reference memory (window 0x0200..0x020F).
        for (int n = 0; n < 1000; n++) begin
            logic        wr;
            logic        in_win;
            logic [15:0] a;
            logic [7:0]  wd;
            logic [7:0]  exp_rd;
            wr     = 1'($urandom_range(0, 1));
            a      = {2'($urandom_range(0, 3)), 10'h020, 4'($urandom_range(0, 15))};
            wd     = 8'($urandom_range(0, 255));
            in_win = (a[15:14] == 2'b00);
            exp_rd = wr ? 8'h00 : (in_win ? ref_mem[a[3:0]] : 8'hFF);
            if (wr && in_win) ref_mem[a[3:0]] = wd;
            do_req(1, wr, a, wd, rd, lat, csc);
            check("rnd_rd",  32'(rd),  32'(exp_rd));
            check("rnd_lat", 32'(lat), !in_win ? 32'd1 : (wr ? 32'd2 : 32'd3));
            check("rnd_cs",  32'(csc), !in_win ? 32'd0 : (wr ? 32'd1 : 32'd2));
        end

        check("bus_safety_violations", 32'(viol), 32'd0);
        check("one_rsp_per_accept", 32'(pulses1), 32'(accepts1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/memory_bus_master.md
Name: memory_bus_master

Overview:
- CPU-side initiator for the 16 kB work-RAM bus: chipSelect, writeEnable, 14-bit address and a shared bidirectional 8-bit data bus.
- Converts single-outstanding CPU load/store requests on a valid/ready handshake into correctly timed bus cycles.
- Captures read data after the RAM's synchronous read latency and returns a one-cycle response.
- Decodes the 16-bit CPU address; only the RAM window generates bus traffic.

Parameters:
- READ_LATENCY, 1, RAM clock-edges from address sample to valid read data (1 = unregistered block-RAM output, 2 = output register enabled); legal range 1..3.
- RAM_BASE, 2'b00, value of CPU address bits [15:14] that selects the RAM window.
- OPEN_BUS, 8'hFF, read data returned for addresses outside the RAM window.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous active-low reset.
- reqValid  input  1  CPU request present.
- reqReady  output  1  block can accept a request this cycle.
- reqWrite  input  1  1 = store, 0 = load; sampled at accept.
- reqAddr  input  16  CPU byte address; sampled at accept.
- reqWdata  input  8  store data; sampled at accept.
- rspValid  output  1  one-cycle pulse: request complete.
- rspData  output  8  load data, valid while rspValid=1; 8'h00 for stores.
- chipSelect  output  1  bus select to RAM.
- writeEnable  output  1  bus write strobe to RAM.
- address  output  14  bus address = reqAddr[13:0].
- data  inout  8  shared data bus; driven only during write cycles, otherwise Z.

Behaviour:
- Reset (async, any state): state=IDLE, reqReady=1, rspValid=0, rspData=00, chipSelect=0, writeEnable=0, address=0000, data released (Z). Takes effect immediately mid-transfer; the aborted request produces no response.
- All bus outputs and the data-bus output enable come from flops; no combinational path from req* to the bus.
- Accept: reqValid & reqReady at a rising edge. reqReady=1 only in IDLE. Request fields are latched at accept and held stable until the response.
- States: IDLE, WRITE, READ, RESPOND.
- IDLE, accept, reqAddr[15:14] != RAM_BASE:
  - Go to RESPOND with no bus activity.
  - rspData = OPEN_BUS for loads, 00 for stores; a store is discarded.
- IDLE, accept, in-window store -> WRITE for exactly 1 cycle:
  - chipSelect=1, writeEnable=1, address, data driven with reqWdata.
  - Then RESPOND with rspData=00.
- IDLE, accept, in-window load -> READ for READ_LATENCY+1 cycles:
  - chipSelect=1, writeEnable=0, data released.
  - data is sampled into rspData at the final READ edge, then RESPOND.
- RESPOND: rspValid=1 for exactly 1 cycle; all bus outputs inactive; then IDLE.
- Latency, accept edge to rspValid high:
  - in-window store: 2 cycles.
  - in-window load: READ_LATENCY+2 cycles.
  - out-of-window: 1 cycle.
- Throughput: next accept no earlier than the edge that ends RESPOND.
- Bus safety invariants:
  - writeEnable=1 only while chipSelect=1; the RAM write strobe does not qualify on select.
  - data is never driven while chipSelect=1 & writeEnable=0.
  - chipSelect and writeEnable are deasserted in the same edge on leaving WRITE.
- rspData holds its last value outside rspValid.
- reqValid dropping while not ready has no effect; there is no cancel.

Test Plan:
- Reset mid-read: assert nReset=0 during READ -> bus outputs 0 and data Z in the same cycle, no rspValid; after release reqReady=1.
- Store: reqAddr=16'h0123, reqWdata=8'hA5, READ_LATENCY=1 -> one cycle with chipSelect=1, writeEnable=1, address=14'h0123, data=A5; rspValid two cycles after accept, rspData=00; RAM model location 0123 = A5.
- Load after store: reqAddr=16'h0123 -> chipSelect held 2 cycles with writeEnable=0, data not driven by master; rspValid 3 cycles after accept with rspData=A5. Repeat with READ_LATENCY=2 -> 4 cycles.
- Out-of-window: load at 16'h8000 -> no chipSelect, rspValid next cycle with rspData=FF. Store 8'h5A at 16'hC010 -> no writeEnable, RAM unchanged.
- Back-to-back: reqValid held high for stores to 3FFF (11) then 0000 (22), then loads from both -> reqReady low between requests, responses in order, read data 11 then 22; the boundary address 3FFF decodes in-window.
- Random stress, 1000 mixed requests against a reference memory model: every load matches the model, exactly one rspValid per accept, and the bus-safety invariants hold on every cycle.
